// File: rtl/pm_vec_driver_if.sv
// rtl/pm_vec_driver_if.sv - pi/po stimulus bus and run handshake between harness and controller
interface pm_vec_driver_if #(
  parameter int PI_WIDTH  = 16,
  parameter int PO_WIDTH  = 13,
  parameter int CNT_WIDTH = 16
);
  logic                 start;
  logic                 abort;
  logic [CNT_WIDTH-1:0] num_vec;
  logic [PO_WIDTH-1:0]  po_in;
  logic [PI_WIDTH-1:0]  pi_out;
  logic                 busy;
  logic                 done;
  logic [15:0]          signature;
  logic [CNT_WIDTH-1:0] vec_count;

  modport master (
    output start, abort, num_vec, po_in,
    input  pi_out, busy, done, signature, vec_count
  );

  modport slave (
    input  start, abort, num_vec, po_in,
    output pi_out, busy, done, signature, vec_count
  );
endinterface

// File: rtl/pm_vec_driver.sv
// rtl/pm_vec_driver.sv - LFSR pattern driver and MISR compactor for pm1-class combinational netlists
module pm_vec_driver #(
  parameter int              PI_WIDTH  = 16,
  parameter int              PO_WIDTH  = 13,
  parameter int              CNT_WIDTH = 16,
  parameter logic [15:0]     LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  pm_vec_driver_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t               state, state_n;
  logic [PI_WIDTH-1:0]  pi_q, pi_n;
  logic [15:0]          sig_q, sig_n;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_n;
  logic [CNT_WIDTH-1:0] num_q, num_n;

  logic [15:0]          po_ext;
  logic [PI_WIDTH-1:0]  pi_step;
  logic [15:0]          sig_step;

  // po_in is zero-extended into the low bits of the MISR input word
  always_comb begin
    po_ext                = '0;
    po_ext[PO_WIDTH-1:0]  = bus.po_in;
    pi_step  = {pi_q[14:0], pi_q[15] ^ pi_q[13] ^ pi_q[12] ^ pi_q[10]};
    sig_step = {sig_q[14:0], sig_q[15] ^ sig_q[13] ^ sig_q[12] ^ sig_q[10]} ^ po_ext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pi_q  <= '0;
      sig_q <= '0;
      cnt_q <= '0;
      num_q <= '0;
    end else begin
      state <= state_n;
      pi_q  <= pi_n;
      sig_q <= sig_n;
      cnt_q <= cnt_n;
      num_q <= num_n;
    end
  end

  always_comb begin
    state_n = state;
    pi_n    = pi_q;
    sig_n   = sig_q;
    cnt_n   = cnt_q;
    num_n   = num_q;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          num_n = bus.num_vec;
          sig_n = '0;
          cnt_n = '0;
          if (bus.num_vec == '0) begin
            state_n = DONE;
            pi_n    = '0;
          end else begin
            state_n = RUN;
            pi_n    = LFSR_SEED;
          end
        end
      end
      RUN: begin
        // abort beats start and suppresses the absorb on its edge
        if (bus.abort) begin
          state_n = IDLE;
          pi_n    = '0;
        end else begin
          sig_n = sig_step;
          cnt_n = cnt_q + CNT_ONE;
          if (cnt_q == num_q - CNT_ONE) begin
            state_n = DONE;
            pi_n    = '0;
          end else begin
            pi_n    = pi_step;
          end
        end
      end
      default: begin
        state_n = IDLE;
        pi_n    = '0;
      end
    endcase
  end

  assign bus.pi_out    = pi_q;
  assign bus.signature = sig_q;
  assign bus.vec_count = cnt_q;
  assign bus.busy      = (state == RUN);
  assign bus.done      = (state == DONE);

endmodule
